// File: rtl/btn_pkg.sv
// Shared constants for the washer front-panel button conditioner: parameter defaults,
// channel index map and a counter-width helper.
package btn_pkg;

    localparam int BTN_DEBOUNCE_DEF = 4;
    localparam int BTN_LONG_DEF     = 16;
    localparam int BTN_REPEAT_DEF   = 8;
    localparam int BTN_CHANNELS     = 5;

    localparam int BTN_RESET = 0;
    localparam int BTN_RUN   = 1;
    localparam int BTN_WATER = 2;
    localparam int BTN_OPEN  = 3;
    localparam int BTN_CLICK = 4;

    // Bits needed for a counter that must be able to hold the value maxCount.
    function automatic int ctrWidth(input int maxCount);
        return $clog2(maxCount + 1);
    endfunction

endpackage

// File: rtl/btn_channel.sv
// One button channel: 2-flop synchroniser, counter debouncer, edge pulses and hold timer.
// Auto-repeat of the press pulse after a long press is built only with BTN_AUTOREPEAT_EN.
module btn_channel
    import btn_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = BTN_DEBOUNCE_DEF,
    parameter int LONG_CYCLES     = BTN_LONG_DEF,
    parameter int REPEAT_CYCLES   = BTN_REPEAT_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic btnRaw,
    output logic btnLevel,
    output logic btnPress,
    output logic btnRelease,
    output logic btnLong
);

    generate
        if (DEBOUNCE_CYCLES < 1 || LONG_CYCLES < 1 || REPEAT_CYCLES < 1) begin : gParamCheck
            $error("btn_channel: DEBOUNCE_CYCLES, LONG_CYCLES and REPEAT_CYCLES must all be >= 1");
        end
    endgenerate

    localparam int DW = ctrWidth(DEBOUNCE_CYCLES);
    localparam int HW = ctrWidth(LONG_CYCLES);
    localparam logic [DW-1:0] DEB_LAST = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [HW-1:0] HOLD_MAX = HW'(LONG_CYCLES);

    logic          sync1Reg, sync2Reg;
    logic [DW-1:0] debReg, debNext;
    logic          levelReg, levelNext;
    logic [HW-1:0] holdReg, holdNext;
    logic          pressReg, pressNext;
    logic          releaseReg, releaseNext;
    logic          longReg, longNext;
    logic          repeatFire;

    always_comb begin
        debNext   = debReg;
        levelNext = levelReg;
        // The level flips on the DEBOUNCE_CYCLES-th consecutive cycle of disagreement.
        if (sync2Reg == levelReg) begin
            debNext = '0;
        end else if (debReg == DEB_LAST) begin
            levelNext = ~levelReg;
            debNext   = '0;
        end else begin
            debNext = debReg + DW'(1);
        end

        holdNext = holdReg;
        if (!levelReg) begin
            holdNext = '0;
        end else if (holdReg != HOLD_MAX) begin
            holdNext = holdReg + HW'(1);
        end

        pressNext   = (levelNext & ~levelReg) | repeatFire;
        releaseNext = ~levelNext & levelReg;
        // Saturation makes this a one-shot until the level drops and clears the timer.
        longNext    = (holdNext == HOLD_MAX) && (holdReg != HOLD_MAX);
    end

`ifdef BTN_AUTOREPEAT_EN
    localparam int RW = ctrWidth(REPEAT_CYCLES);
    localparam logic [RW-1:0] REP_LAST = RW'(REPEAT_CYCLES - 1);

    logic [RW-1:0] repReg, repNext;

    always_comb begin
        repNext    = repReg;
        repeatFire = 1'b0;
        if (!levelReg) begin
            repNext = '0;
        end else if (holdReg == HOLD_MAX) begin
            if (repReg == REP_LAST) begin
                repNext    = '0;
                repeatFire = 1'b1;
            end else begin
                repNext = repReg + RW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            repReg <= '0;
        end else begin
            repReg <= repNext;
        end
    end
`else
    assign repeatFire = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1Reg   <= 1'b0;
            sync2Reg   <= 1'b0;
            debReg     <= '0;
            levelReg   <= 1'b0;
            holdReg    <= '0;
            pressReg   <= 1'b0;
            releaseReg <= 1'b0;
            longReg    <= 1'b0;
        end else begin
            sync1Reg   <= btnRaw;
            sync2Reg   <= sync1Reg;
            debReg     <= debNext;
            levelReg   <= levelNext;
            holdReg    <= holdNext;
            pressReg   <= pressNext;
            releaseReg <= releaseNext;
            longReg    <= longNext;
        end
    end

    assign btnLevel   = levelReg;
    assign btnPress   = pressReg;
    assign btnRelease = releaseReg;
    assign btnLong    = longReg;

endmodule

// File: rtl/btn_conditioner.sv
// N independent button channels between the front-panel pads and the control FSMs.
// Define BTN_AUTOREPEAT_EN to add press auto-repeat after a long press.
module btn_conditioner
    import btn_pkg::*;
#(
    parameter int N               = BTN_CHANNELS,
    parameter int DEBOUNCE_CYCLES = BTN_DEBOUNCE_DEF,
    parameter int LONG_CYCLES     = BTN_LONG_DEF,
    parameter int REPEAT_CYCLES   = BTN_REPEAT_DEF
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [N-1:0] btn_raw,
    output logic [N-1:0] btn_level,
    output logic [N-1:0] btn_press,
    output logic [N-1:0] btn_release,
    output logic [N-1:0] btn_long
);

    generate
        for (genvar gi = 0; gi < N; gi++) begin : gChannel
            btn_channel #(
                .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
                .LONG_CYCLES     (LONG_CYCLES),
                .REPEAT_CYCLES   (REPEAT_CYCLES)
            ) uChannel (
                .clk        (clk),
                .reset      (reset),
                .btnRaw     (btn_raw[gi]),
                .btnLevel   (btn_level[gi]),
                .btnPress   (btn_press[gi]),
                .btnRelease (btn_release[gi]),
                .btnLong    (btn_long[gi])
            );
        end
    endgenerate

endmodule

// File: tb/tb_btn_conditioner.sv
// Scoreboard bench for btn_conditioner: expected events are queued as stimulus is driven
// and matched against events seen on the outputs; honours BTN_AUTOREPEAT_EN.
module tb_btn_conditioner;

    localparam int N    = 5;
    localparam int DEB  = 4;
    localparam int LONG = 16;
    localparam int REP  = 8;
    localparam int LAT  = DEB + 2;
`ifdef BTN_AUTOREPEAT_EN
    localparam bit AUTO = 1'b1;
`else
    localparam bit AUTO = 1'b0;
`endif

    localparam int K_UP = 0, K_DN = 1, K_PRESS = 2, K_REL = 3, K_LONG = 4;

    typedef struct {
        int ch;
        int kind;
        int at;
    } evt_t;

    logic         clk     = 1'b0;
    logic         reset   = 1'b1;
    logic [N-1:0] btn_raw = '1;
    logic [N-1:0] btn_level, btn_press, btn_release, btn_long;

    int           edgeCnt    = 0;
    int           compared   = 0;
    int           mismatched = 0;
    evt_t         expQ[$];
    evt_t         obsQ[$];
    logic [N-1:0] prevLevel  = '0;

    btn_conditioner #(
        .N               (N),
        .DEBOUNCE_CYCLES (DEB),
        .LONG_CYCLES     (LONG),
        .REPEAT_CYCLES   (REP)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .btn_raw     (btn_raw),
        .btn_level   (btn_level),
        .btn_press   (btn_press),
        .btn_release (btn_release),
        .btn_long    (btn_long)
    );

    always #5 clk = ~clk;

    always @(posedge clk) edgeCnt <= edgeCnt + 1;

    function automatic void pushObs(int ch, int kind);
        evt_t e;
        e.ch = ch; e.kind = kind; e.at = edgeCnt;
        obsQ.push_back(e);
    endfunction

    // Output monitor, sampled on the falling edge.
    always @(negedge clk) begin
        for (int c = 0; c < N; c++) begin
            if (btn_level[c] === 1'b1 && prevLevel[c] !== 1'b1) pushObs(c, K_UP);
            if (btn_level[c] === 1'b0 && prevLevel[c] === 1'b1) pushObs(c, K_DN);
            if (btn_press[c] === 1'b1)   pushObs(c, K_PRESS);
            if (btn_release[c] === 1'b1) pushObs(c, K_REL);
            if (btn_long[c] === 1'b1)    pushObs(c, K_LONG);
        end
        prevLevel = btn_level;
    end

    function automatic string kindName(int k);
        case (k)
            K_UP:    return "level_up";
            K_DN:    return "level_dn";
            K_PRESS: return "press";
            K_REL:   return "release";
            default: return "long";
        endcase
    endfunction

    function automatic void pushExp(int ch, int kind, int at);
        evt_t e;
        e.ch = ch; e.kind = kind; e.at = at;
        expQ.push_back(e);
    endfunction

    // Expected events for a clean raw pulse: rise driven before edge rise+1, fall before fall+1.
    function automatic void expectHold(int ch, int rise, int fall);
        pushExp(ch, K_UP, rise + LAT);
        pushExp(ch, K_PRESS, rise + LAT);
        if (rise + LAT + LONG <= fall + LAT) pushExp(ch, K_LONG, rise + LAT + LONG);
        if (AUTO) begin
            for (int t = rise + LAT + LONG + REP; t <= fall + LAT; t += REP) pushExp(ch, K_PRESS, t);
        end
        pushExp(ch, K_DN, fall + LAT);
        pushExp(ch, K_REL, fall + LAT);
    endfunction

    function automatic bit takeEvent(input evt_t e);
        foreach (obsQ[i]) begin
            if (obsQ[i].ch == e.ch && obsQ[i].kind == e.kind && obsQ[i].at == e.at) begin
                obsQ.delete(i);
                return 1'b1;
            end
        end
        return 1'b0;
    endfunction

    task automatic stepTo(int target);
        while (edgeCnt < target) @(negedge clk);
    endtask

    task automatic test_reset();
        int e0, e1;
        evt_t e;
        bit got;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            compared++;
            if ({btn_level, btn_press, btn_release, btn_long} !== '0) begin
                mismatched++;
                $display("FAIL reset_outputs: cycle %0d got %b required 0", i,
                         {btn_level, btn_press, btn_release, btn_long});
            end
        end
        reset = 1'b0;
        e0 = edgeCnt;
        stepTo(e0 + LAT - 1);
        compared++;
        if (btn_level !== 5'b00000) begin
            mismatched++;
            $display("FAIL reset_level_early: btn_level=%b required 00000", btn_level);
        end
        stepTo(e0 + LAT);
        compared++;
        if (btn_level !== 5'b11111 || btn_press !== 5'b11111) begin
            mismatched++;
            $display("FAIL reset_rise: level=%b press=%b required 11111/11111", btn_level, btn_press);
        end
        stepTo(e0 + 10);
        btn_raw = '0;
        e1 = edgeCnt;
        for (int c = 0; c < N; c++) expectHold(c, e0, e1);
        stepTo(e1 + 30);
        while (expQ.size() > 0) begin
            e = expQ.pop_front(); got = takeEvent(e); compared++;
            if (got !== 1'b1) begin
                mismatched++;
                $display("FAIL reset: ch%0d %s required at edge %0d, not seen", e.ch, kindName(e.kind), e.at);
            end else $display("reset: ch%0d %s @%0d ok", e.ch, kindName(e.kind), e.at);
        end
        compared++;
        if (obsQ.size() !== 0) begin
            mismatched++;
            foreach (obsQ[i]) $display("FAIL reset: unexpected ch%0d %s at edge %0d, required none", obsQ[i].ch, kindName(obsQ[i].kind), obsQ[i].at);
            obsQ.delete();
        end
    endtask

    task automatic test_press_long();
        int e0;
        evt_t e;
        bit got;
        e0 = edgeCnt;
        btn_raw[0] = 1'b1;
        stepTo(e0 + LAT + 1);
        compared++;
        if (btn_press !== 5'b00000 || btn_level !== 5'b00001) begin
            mismatched++;
            $display("FAIL press_width: press=%b level=%b required 00000/00001", btn_press, btn_level);
        end
        stepTo(e0 + LAT + LONG - 1);
        compared++;
        if (btn_long !== 5'b00000) begin
            mismatched++;
            $display("FAIL long_early: btn_long=%b required 00000", btn_long);
        end
        stepTo(e0 + LAT + LONG);
        compared++;
        if (btn_long !== 5'b00001) begin
            mismatched++;
            $display("FAIL long_fire: btn_long=%b required 00001", btn_long);
        end
        stepTo(e0 + 30);
        btn_raw[0] = 1'b0;
        expectHold(0, e0, e0 + 30);
        stepTo(e0 + 70);
        while (expQ.size() > 0) begin
            e = expQ.pop_front(); got = takeEvent(e); compared++;
            if (got !== 1'b1) begin
                mismatched++;
                $display("FAIL press_long: ch%0d %s required at edge %0d, not seen", e.ch, kindName(e.kind), e.at);
            end else $display("press_long: ch%0d %s @%0d ok", e.ch, kindName(e.kind), e.at);
        end
        compared++;
        if (obsQ.size() !== 0) begin
            mismatched++;
            foreach (obsQ[i]) $display("FAIL press_long: unexpected ch%0d %s at edge %0d, required none", obsQ[i].ch, kindName(obsQ[i].kind), obsQ[i].at);
            obsQ.delete();
        end
    endtask

    task automatic test_glitch();
        int e0, e1;
        evt_t e;
        bit got;
        e0 = edgeCnt;
        btn_raw[1] = 1'b1;
        stepTo(e0 + DEB - 1);
        btn_raw[1] = 1'b0;
        stepTo(e0 + LAT);
        compared++;
        if (btn_level[1] !== 1'b0) begin
            mismatched++;
            $display("FAIL glitch_level: btn_level[1]=%b required 0", btn_level[1]);
        end
        stepTo(e0 + 20);
        // A pulse of exactly DEB cycles is the shortest one accepted.
        e1 = edgeCnt;
        btn_raw[1] = 1'b1;
        stepTo(e1 + DEB);
        btn_raw[1] = 1'b0;
        expectHold(1, e1, e1 + DEB);
        stepTo(e1 + 40);
        while (expQ.size() > 0) begin
            e = expQ.pop_front(); got = takeEvent(e); compared++;
            if (got !== 1'b1) begin
                mismatched++;
                $display("FAIL glitch: ch%0d %s required at edge %0d, not seen", e.ch, kindName(e.kind), e.at);
            end else $display("glitch: ch%0d %s @%0d ok", e.ch, kindName(e.kind), e.at);
        end
        compared++;
        if (obsQ.size() !== 0) begin
            mismatched++;
            foreach (obsQ[i]) $display("FAIL glitch: unexpected ch%0d %s at edge %0d, required none", obsQ[i].ch, kindName(obsQ[i].kind), obsQ[i].at);
            obsQ.delete();
        end
    endtask

    task automatic test_back_to_back();
        int e0;
        evt_t e;
        bit got;
        e0 = edgeCnt;
        btn_raw[3:2] = 2'b11;
        stepTo(e0 + 10);
        btn_raw[3:2] = 2'b00;
        expectHold(2, e0, e0 + 10);
        expectHold(3, e0, e0 + 10);
        stepTo(e0 + 10 + LAT);
        compared++;
        if (btn_release !== 5'b01100) begin
            mismatched++;
            $display("FAIL parallel_release: btn_release=%b required 01100", btn_release);
        end
        stepTo(e0 + 50);
        while (expQ.size() > 0) begin
            e = expQ.pop_front(); got = takeEvent(e); compared++;
            if (got !== 1'b1) begin
                mismatched++;
                $display("FAIL parallel: ch%0d %s required at edge %0d, not seen", e.ch, kindName(e.kind), e.at);
            end else $display("parallel: ch%0d %s @%0d ok", e.ch, kindName(e.kind), e.at);
        end
        compared++;
        if (obsQ.size() !== 0) begin
            mismatched++;
            foreach (obsQ[i]) $display("FAIL parallel: unexpected ch%0d %s at edge %0d, required none", obsQ[i].ch, kindName(obsQ[i].kind), obsQ[i].at);
            obsQ.delete();
        end
    endtask

    task automatic test_autorepeat();
        int e0;
        evt_t e;
        bit got;
        e0 = edgeCnt;
        btn_raw[4] = 1'b1;
        stepTo(e0 + LAT + LONG + REP);
        compared++;
        if (btn_press[4] !== AUTO) begin
            mismatched++;
            $display("FAIL repeat_first: btn_press[4]=%b required %b", btn_press[4], AUTO);
        end
        stepTo(e0 + 58);
        btn_raw[4] = 1'b0;
        expectHold(4, e0, e0 + 58);
        stepTo(e0 + 100);
        while (expQ.size() > 0) begin
            e = expQ.pop_front(); got = takeEvent(e); compared++;
            if (got !== 1'b1) begin
                mismatched++;
                $display("FAIL autorepeat: ch%0d %s required at edge %0d, not seen", e.ch, kindName(e.kind), e.at);
            end else $display("autorepeat: ch%0d %s @%0d ok", e.ch, kindName(e.kind), e.at);
        end
        compared++;
        if (obsQ.size() !== 0) begin
            mismatched++;
            foreach (obsQ[i]) $display("FAIL autorepeat: unexpected ch%0d %s at edge %0d, required none", obsQ[i].ch, kindName(obsQ[i].kind), obsQ[i].at);
            obsQ.delete();
        end
    endtask

    task automatic test_reset_mid();
        int e0, er;
        evt_t e;
        bit got;
        e0 = edgeCnt;
        btn_raw[0] = 1'b1;
        pushExp(0, K_UP, e0 + LAT);
        pushExp(0, K_PRESS, e0 + LAT);
        stepTo(e0 + 14);
        reset = 1'b1;
        pushExp(0, K_DN, e0 + 15);
        stepTo(e0 + 15);
        compared++;
        if ({btn_level, btn_press, btn_release, btn_long} !== '0) begin
            mismatched++;
            $display("FAIL reset_mid_clear: outputs %b required 0", {btn_level, btn_press, btn_release, btn_long});
        end
        stepTo(e0 + 16);
        reset = 1'b0;
        er = edgeCnt;
        stepTo(er + LAT);
        compared++;
        if (btn_level !== 5'b00001 || btn_press !== 5'b00001) begin
            mismatched++;
            $display("FAIL reset_mid_repress: level=%b press=%b required 00001/00001", btn_level, btn_press);
        end
        stepTo(er + LAT + LONG);
        compared++;
        if (btn_long !== 5'b00001) begin
            mismatched++;
            $display("FAIL reset_mid_long: btn_long=%b required 00001", btn_long);
        end
        stepTo(er + 30);
        btn_raw[0] = 1'b0;
        expectHold(0, er, er + 30);
        stepTo(er + 70);
        while (expQ.size() > 0) begin
            e = expQ.pop_front(); got = takeEvent(e); compared++;
            if (got !== 1'b1) begin
                mismatched++;
                $display("FAIL reset_mid: ch%0d %s required at edge %0d, not seen", e.ch, kindName(e.kind), e.at);
            end else $display("reset_mid: ch%0d %s @%0d ok", e.ch, kindName(e.kind), e.at);
        end
        compared++;
        if (obsQ.size() !== 0) begin
            mismatched++;
            foreach (obsQ[i]) $display("FAIL reset_mid: unexpected ch%0d %s at edge %0d, required none", obsQ[i].ch, kindName(obsQ[i].kind), obsQ[i].at);
            obsQ.delete();
        end
    endtask

    initial begin
        test_reset();
        test_press_long();
        test_glitch();
        test_back_to_back();
        test_autorepeat();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/btn_conditioner.md
# btn_conditioner

Parametrised multi-channel front-end for the washer's front-panel buttons and click input. Every raw pad goes through a 2-flop synchroniser, a counter debouncer and an edge detector. Each channel produces a clean level, one-cycle press and release pulses, and a one-shot long-press pulse. It sits between the board pins and the control FSMs (state controller, model), and generalises the single-channel synchroniser and edge-detector pair into N independent channels with hold-time classification.

## Interface
Parameters:
- `N`, 5: number of button channels.
- `DEBOUNCE_CYCLES`, 4: consecutive stable cycles needed to accept a level change (≥1).
- `LONG_CYCLES`, 16: cycles after a press before the long-press pulse fires (≥1).
- `REPEAT_CYCLES`, 8: auto-repeat period; used only with `BTN_AUTOREPEAT_EN` (≥1).

Ports:
- `clk` in 1: single system clock; all logic on rising edge.
- `reset` in 1: synchronous, active-high; clears all state.
- `btn_raw` in N: asynchronous raw button inputs, active-high.
- `btn_level` out N: debounced level.
- `btn_press` out N: one-cycle pulse on each debounced rise (plus auto-repeat pulses when enabled).
- `btn_release` out N: one-cycle pulse on each debounced fall.
- `btn_long` out N: one-cycle pulse, at most once per press.

## Operation
- Channels are fully independent. Simultaneous events on different channels are handled in parallel with no arbitration.
- Synchroniser: `s1 <= btn_raw`, `s2 <= s1`. Both flops reset to 0.
- Debounce counter, `$clog2(DEBOUNCE_CYCLES+1)` bits:
  - If `s2 == level`, the counter clears to 0.
  - Else, if the counter equals `DEBOUNCE_CYCLES-1`, `level` toggles and the counter clears.
  - Else, the counter increments.
  - Any bounce shorter than `DEBOUNCE_CYCLES` cycles restarts the count and produces no output.
- Pulses:
  - `btn_press` is registered and high for exactly the cycle in which `level` first reads 1.
  - `btn_release` is the same for the cycle in which `level` first reads 0.
- Hold counter, `$clog2(LONG_CYCLES+1)` bits:
  - Cleared while `level=0`.
  - Increments while `level=1`, saturating at `LONG_CYCLES`.
  - `btn_long` pulses on the cycle the counter reaches `LONG_CYCLES`.
  - A release before that point produces no `btn_long`.
  - No second `btn_long` until a release and a new press.
- Reset mid-operation:
  - All outputs and counters go to 0 on the cycle after the reset edge.
  - No release pulse is generated.
  - A button still held at reset deassertion is treated as a fresh press.

## Timing
- Reset values: `btn_level`, `btn_press`, `btn_release`, `btn_long` are all 0.
- Latency: a raw change stable from before edge 1 is reflected in `btn_level` and its pulse after edge `DEBOUNCE_CYCLES+2`. With the defaults, that is edge 6.
- `btn_long` asserts exactly `LONG_CYCLES` cycles after the `btn_press` cycle, provided the button is held throughout.
- All outputs are registered; there are no combinational paths from `btn_raw`.

## Configuration
- `BTN_AUTOREPEAT_EN` defined:
  - After `btn_long`, a repeat counter pulses `btn_press` every `REPEAT_CYCLES` cycles while `level=1`.
  - The first repeat pulse comes `REPEAT_CYCLES` cycles after `btn_long`.
  - The repeat counter clears on release and on reset.
- Not defined: the repeat counter and its logic are absent. `btn_press` fires once per physical press.

## Structure
- Shared package `btn_pkg` holds:
  - Default parameter constants (`BTN_DEBOUNCE_DEF`, `BTN_LONG_DEF`, `BTN_REPEAT_DEF`).
  - Washer channel index constants (`BTN_RESET`, `BTN_RUN`, `BTN_WATER`, `BTN_OPEN`, `BTN_CLICK`).
- One sub-module, `btn_channel`: the per-channel synchroniser, debouncer, hold counter and optional repeat counter. It is instantiated N times in a generate loop.
- Parameter legality (all three counts ≥1) is checked at elaboration.

## Test plan
Bench settings: N=5, D=4, LONG=16, REPEAT=8.
- Reset asserted for 3 cycles with `btn_raw=5'b11111` → all outputs 0 during reset. After deassertion, all `btn_level` bits rise at edge 6, with one `btn_press` pulse per channel.
- ch0 raw rises and is held 30 cycles → `btn_level[0]` rises at edge 6. `btn_press[0]` is high one cycle. `btn_long[0]` fires 16 cycles later, exactly once.
- ch1 glitch high for 3 cycles, then low → `btn_level[1]`, `btn_press[1]` and `btn_release[1]` stay 0 throughout.
- ch2 held 10 cycles after press, then released → `btn_release[2]` pulses 6 edges after the raw fall, with no `btn_long[2]`. Meanwhile ch3 pressed on the same cycle shows identical independent timing.
- ch4 held 40 cycles past `btn_long` → with `BTN_AUTOREPEAT_EN`, `btn_press[4]` pulses at long+8, +16, +24, +32, +40. Without it, no further pulses.
- `reset` asserted while ch0 is held mid-hold-count → outputs clear next cycle with no release pulse. A new press is seen at edge 6 after deassertion, and `btn_long[0]` fires 16 cycles after that.
